// File: rtl/xor_mask_pipe_if.sv
// Stream bundle for xor_mask_pipe: producer-side and consumer-side handshakes plus status.
// out_parity exists only when XOR_PIPE_PARITY_EN is defined.
interface xor_mask_pipe_if #(
  parameter int unsigned WIDTH = 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [15:0]      out_count;
`ifdef XOR_PIPE_PARITY_EN
  logic             out_parity;
`endif

  modport master (
`ifdef XOR_PIPE_PARITY_EN
    input  out_parity,
`endif
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
`ifdef XOR_PIPE_PARITY_EN
    output out_parity,
`endif
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/xor_mask_pipe.sv
// Elastic DEPTH-stage pipe that XORs each word with MASK truncated to WIDTH bits.
// Optional per-word parity lane enabled by XOR_PIPE_PARITY_EN.
module xor_mask_pipe #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2,
  parameter              MASK  = 1
) (
  input logic              clk,
  input logic              rst_n,
  xor_mask_pipe_if.slave   bus
);

  // Oversized masks are silently truncated to the datapath width.
  localparam logic [WIDTH-1:0] M = WIDTH'(MASK);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [15:0]      count_q, count_d;
  logic             in_accept;
`ifdef XOR_PIPE_PARITY_EN
  logic [DEPTH-1:0] p_q, p_d;
`endif

  // Advance flags ripple back from the output so a full pipe can accept and emit in one cycle.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = v_q[DEPTH-1] & bus.out_ready;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      adv[DEPTH-1-i] = v_q[DEPTH-1-i] & (~v_q[DEPTH-i] | adv[DEPTH-i]);
    end
  end

  assign bus.in_ready = ~v_q[0] | adv[0];
  assign in_accept    = bus.in_valid & bus.in_ready;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
`ifdef XOR_PIPE_PARITY_EN
    p_d = p_q;
`endif
    if (in_accept) begin
      v_d[0] = 1'b1;
      d_d[0] = bus.in_data ^ M;
`ifdef XOR_PIPE_PARITY_EN
      p_d[0] = ^(bus.in_data ^ M);
`endif
    end else if (adv[0]) begin
      v_d[0] = 1'b0;
    end
    for (int unsigned k = 1; k < DEPTH; k++) begin
      if (adv[k-1]) begin
        v_d[k] = 1'b1;
        d_d[k] = d_q[k-1];
`ifdef XOR_PIPE_PARITY_EN
        p_d[k] = p_q[k-1];
`endif
      end else if (adv[k]) begin
        v_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (adv[DEPTH-1]) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      d_q     <= '{default: '0};
      count_q <= '0;
`ifdef XOR_PIPE_PARITY_EN
      p_q     <= '0;
`endif
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      count_q <= count_d;
`ifdef XOR_PIPE_PARITY_EN
      p_q     <= p_d;
`endif
    end
  end

  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = d_q[DEPTH-1];
  assign bus.out_count = count_q;
`ifdef XOR_PIPE_PARITY_EN
  assign bus.out_parity = p_q[DEPTH-1];
`endif

endmodule

// File: tb/tb_xor_mask_pipe.sv
// Directed bench for xor_mask_pipe: mask truncation, streaming, backpressure, wrap, reset.
// Parity lane is exercised only when XOR_PIPE_PARITY_EN is defined.
module tb_xor_mask_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  xor_mask_pipe_if #(.WIDTH(8)) m ();
  xor_mask_pipe #(.WIDTH(8), .DEPTH(3), .MASK('h1A5)) dut (.clk(clk), .rst_n(rst_n), .bus(m));

  logic tr_valid = 1'b0;
  logic tr_data  = 1'b0;
  xor_mask_pipe_if #(.WIDTH(1)) t0 ();
  xor_mask_pipe_if #(.WIDTH(1)) t1 ();
  xor_mask_pipe_if #(.WIDTH(1)) t2 ();
  xor_mask_pipe_if #(.WIDTH(1)) t3 ();
  assign t0.in_valid = tr_valid;  assign t0.in_data = tr_data;  assign t0.out_ready = 1'b1;
  assign t1.in_valid = tr_valid;  assign t1.in_data = tr_data;  assign t1.out_ready = 1'b1;
  assign t2.in_valid = tr_valid;  assign t2.in_data = tr_data;  assign t2.out_ready = 1'b1;
  assign t3.in_valid = tr_valid;  assign t3.in_data = tr_data;  assign t3.out_ready = 1'b1;
  xor_mask_pipe #(.WIDTH(1), .DEPTH(1), .MASK(0)) dut_m0 (.clk(clk), .rst_n(rst_n), .bus(t0));
  xor_mask_pipe #(.WIDTH(1), .DEPTH(1), .MASK(1)) dut_m1 (.clk(clk), .rst_n(rst_n), .bus(t1));
  xor_mask_pipe #(.WIDTH(1), .DEPTH(1), .MASK(2)) dut_m2 (.clk(clk), .rst_n(rst_n), .bus(t2));
  xor_mask_pipe #(.WIDTH(1), .DEPTH(1), .MASK(3)) dut_m3 (.clk(clk), .rst_n(rst_n), .bus(t3));

`ifdef XOR_PIPE_PARITY_EN
  xor_mask_pipe_if #(.WIDTH(4)) pif ();
  xor_mask_pipe #(.WIDTH(4), .DEPTH(2), .MASK('h3)) dut_par (.clk(clk), .rst_n(rst_n), .bus(pif));
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int unsigned acc;
  int unsigned cyc;

  initial begin
    m.in_valid = 1'b0;
    m.in_data  = '0;
    m.out_ready = 1'b0;
`ifdef XOR_PIPE_PARITY_EN
    pif.in_valid = 1'b0;
    pif.in_data  = '0;
    pif.out_ready = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", m.out_valid, 0);
    check("rst_out_data",  m.out_data, 0);
    check("rst_out_count", m.out_count, 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", m.in_ready, 1);

    // truncation: M = 0,1,0,1 for MASK = 0,1,2,3
    tr_valid = 1'b1;
    tr_data  = 1'b0;
    step();
    check("trunc_valid", t0.out_valid, 1);
    check("trunc_m0_d0", t0.out_data, 0);
    check("trunc_m1_d0", t1.out_data, 1);
    check("trunc_m2_d0", t2.out_data, 0);
    check("trunc_m3_d0", t3.out_data, 1);
    tr_data = 1'b1;
    step();
    check("trunc_m0_d1", t0.out_data, 1);
    check("trunc_m1_d1", t1.out_data, 0);
    check("trunc_m2_d1", t2.out_data, 1);
    check("trunc_m3_d1", t3.out_data, 0);
    tr_valid = 1'b0;
    step();
    check("trunc_drained", t3.out_valid, 0);

    // streaming, M = 0xA5
    m.out_ready = 1'b1;
    m.in_valid  = 1'b1;
    m.in_data   = 8'h00;
    step();
    check("stream_lat1", m.out_valid, 0);
    m.in_data = 8'hFF;
    step();
    check("stream_lat2", m.out_valid, 0);
    m.in_data = 8'h3C;
    step();
    m.in_valid = 1'b0;
    check("stream_v0", m.out_valid, 1);
    check("stream_d0", m.out_data, 8'hA5);
    step();
    check("stream_v1", m.out_valid, 1);
    check("stream_d1", m.out_data, 8'h5A);
    check("stream_c1", m.out_count, 1);
    step();
    check("stream_v2", m.out_valid, 1);
    check("stream_d2", m.out_data, 8'h99);
    step();
    check("stream_empty", m.out_valid, 0);
    check("stream_count", m.out_count, 3);

    // backpressure
    m.out_ready = 1'b0;
    m.in_valid  = 1'b1;
    m.in_data   = 8'h10;
    #1 check("bp_acc0", m.in_ready, 1);
    step();
    m.in_data = 8'h11;
    #1 check("bp_acc1", m.in_ready, 1);
    step();
    m.in_data = 8'h12;
    #1 check("bp_acc2", m.in_ready, 1);
    step();
    m.in_data = 8'h13;
    #1 check("bp_full", m.in_ready, 0);
    step();
    check("bp_hold_ready", m.in_ready, 0);
    check("bp_hold_data", m.out_data, 8'hB5);
    m.out_ready = 1'b1;
    #1 check("bp_no_bubble", m.in_ready, 1);
    step();
    check("bp_out1", m.out_data, 8'hB4);
    m.in_data = 8'h14;
    #1 check("bp_acc4", m.in_ready, 1);
    step();
    m.in_valid = 1'b0;
    check("bp_out2", m.out_data, 8'hB7);
    step();
    check("bp_out3", m.out_data, 8'hB6);
    step();
    check("bp_out4", m.out_data, 8'hB1);
    check("bp_out4_v", m.out_valid, 1);
    step();
    check("bp_empty", m.out_valid, 0);
    check("bp_count", m.out_count, 8);

    // wrap: clear the counter, then 65537 transfers
    rst_n = 1'b0;
    #2;
    check("wrap_rst_count", m.out_count, 0);
    rst_n = 1'b1;
    m.in_valid  = 1'b1;
    m.out_ready = 1'b1;
    acc = 0;
    cyc = 0;
    #1;
    while (acc < 65537 && cyc < 70000) begin
      m.in_data = acc[7:0];
      #1;
      if (m.in_ready) acc++;
      step();
      cyc++;
    end
    m.in_valid = 1'b0;
    check("wrap_gapless", cyc, 65537);
    step();
    step();
    step();
    check("wrap_count", m.out_count, 16'h0001);
    check("wrap_empty", m.out_valid, 0);

    // reset with words in flight
    m.out_ready = 1'b0;
    m.in_valid  = 1'b1;
    m.in_data   = 8'h55;
    step();
    m.in_data = 8'h66;
    step();
    m.in_valid = 1'b0;
    step();
    check("mid_valid", m.out_valid, 1);
    check("mid_data", m.out_data, 8'hF0);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", m.out_valid, 0);
    check("async_count", m.out_count, 0);
    check("async_data", m.out_data, 0);
    check("async_ready", m.in_ready, 1);
    rst_n = 1'b1;
    m.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("no_stale", m.out_valid, 0);
    end
    m.in_valid = 1'b1;
    m.in_data  = 8'h0F;
    step();
    m.in_valid = 1'b0;
    step();
    step();
    check("resume_valid", m.out_valid, 1);
    check("resume_data", m.out_data, 8'hAA);
    step();
    check("resume_count", m.out_count, 1);

`ifdef XOR_PIPE_PARITY_EN
    pif.out_ready = 1'b1;
    pif.in_valid  = 1'b1;
    pif.in_data   = 4'h0;
    step();
    pif.in_data = 4'h1;
    step();
    pif.in_valid = 1'b0;
    check("par_d0", pif.out_data, 4'h3);
    check("par_p0", pif.out_parity, 0);
    step();
    check("par_d1", pif.out_data, 4'h2);
    check("par_p1", pif.out_parity, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
